// File: rtl/picorv32_wb_master_if.sv
// Wishbone B4 classic bus bundle between the picorv32 bridge (master) and
// the peripheral interconnect (slave).
interface picorv32_wb_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/picorv32_wb_master.sv
// picorv32 native memory port to Wishbone classic initiator: one bus cycle per
// CPU access, with retry backoff, slave timeout and a sticky error record.
module picorv32_wb_master #(
  parameter int          TIMEOUT   = 255,
  parameter int          MAX_RETRY = 3,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  picorv32_wb_master_if.master wb,
  input  logic        bus_err_clr_i,
  output logic        bus_err_o,
  output logic [31:0] err_addr_o
);

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        fail;

  // The instruction-fetch flag carries no meaning on this bus.
  logic unused_instr;
  assign unused_instr = mem_instr;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      retry_q    <= '0;
      tmo_q      <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    fail       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_valid && !mem_ready) begin
          adr_d   = mem_addr;
          dat_d   = mem_wdata;
          we_d    = |mem_wstrb;
          sel_d   = (|mem_wstrb) ? mem_wstrb : 4'b1111;
          retry_d = '0;
          tmo_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Response priority is err > ack > rty; timeout only when silent.
        if (wb.wb_err_i) begin
          fail = 1'b1;
        end else if (wb.wb_ack_i) begin
          rdata_d = we_q ? 32'h0 : wb.wb_dat_i;
          state_d = DONE;
        end else if (wb.wb_rty_i) begin
          if (retry_q >= 4'(MAX_RETRY)) begin
            fail = 1'b1;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = BACKOFF;
          end
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end

        if (fail) begin
          rdata_d    = ERR_DATA;
          err_addr_d = adr_q;
          state_d    = DONE;
        end
      end
      BACKOFF: begin
        tmo_d   = '0;
        state_d = BUS;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new failure outranks a simultaneous clear request.
    bus_err_d = fail | (bus_err_q & ~bus_err_clr_i);
  end

  assign mem_ready   = (state_q == DONE);
  assign mem_rdata   = rdata_q;
  assign bus_err_o   = bus_err_q;
  assign err_addr_o  = err_addr_q;

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = (state_q == BUS);
  assign wb.wb_stb_o = (state_q == BUS);
  assign wb.wb_cti_o = 3'b000;
  assign wb.wb_bte_o = 2'b00;

endmodule

// File: tb/tb_picorv32_wb_master.sv
// Directed bench for picorv32_wb_master with a configurable Wishbone slave
// model (wait states, retry count, silent, simultaneous ack+err).
module tb_picorv32_wb_master;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err_clr_i;
  logic        bus_err_o;
  logic [31:0] err_addr_o;

  int n_vec = 0;
  int n_err = 0;

  picorv32_wb_master_if wb ();

  picorv32_wb_master #(
    .TIMEOUT  (8),
    .MAX_RETRY(3),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .mem_valid    (mem_valid),
    .mem_instr    (mem_instr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .wb           (wb),
    .bus_err_clr_i(bus_err_clr_i),
    .bus_err_o    (bus_err_o),
    .err_addr_o   (err_addr_o)
  );

  always #5 i_clk = ~i_clk;

  // Slave model configuration and bus monitor.
  logic [31:0] slv_rdata;
  int          slv_wait;
  int          slv_rty_n;
  logic        slv_silent;
  logic        slv_both;
  logic        slv_clr;

  int          stb_cnt;
  int          rty_seen;
  int          stb_total;
  int          stb_rises;
  logic        stb_prev;
  logic [3:0]  sel_seen;
  logic        we_seen;
  logic [31:0] adr_seen;
  logic [31:0] dat_seen;

  always_comb begin
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b0;
    wb.wb_rty_i = 1'b0;
    wb.wb_dat_i = slv_rdata;
    if (wb.wb_stb_o && wb.wb_cyc_o && !slv_silent && stb_cnt >= slv_wait) begin
      if (rty_seen < slv_rty_n) begin
        wb.wb_rty_i = 1'b1;
      end else begin
        wb.wb_ack_i = 1'b1;
        wb.wb_err_i = slv_both;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (slv_clr) begin
      stb_cnt   <= 0;
      rty_seen  <= 0;
      stb_total <= 0;
      stb_rises <= 0;
      stb_prev  <= 1'b0;
      sel_seen  <= '0;
      we_seen   <= 1'b0;
      adr_seen  <= '0;
      dat_seen  <= '0;
    end else begin
      stb_prev <= wb.wb_stb_o;
      if (wb.wb_stb_o) begin
        stb_total <= stb_total + 1;
        if (!stb_prev) stb_rises <= stb_rises + 1;
        sel_seen <= wb.wb_sel_o;
        we_seen  <= wb.wb_we_o;
        adr_seen <= wb.wb_adr_o;
        dat_seen <= wb.wb_dat_o;
        if (wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i) stb_cnt <= 0;
        else stb_cnt <= stb_cnt + 1;
        if (wb.wb_rty_i) rty_seen <= rty_seen + 1;
      end else begin
        stb_cnt <= 0;
      end
    end
  end

  task automatic setup_slave(input int wt, input int rty_n, input logic silent,
                             input logic both, input logic [31:0] rd);
    slv_wait   = wt;
    slv_rty_n  = rty_n;
    slv_silent = silent;
    slv_both   = both;
    slv_rdata  = rd;
    slv_clr    = 1'b1;
    @(posedge i_clk); #1;
    slv_clr    = 1'b0;
  endtask

  // Issues one CPU access; lat counts edges from mem_valid to mem_ready
  // (bounded at 100, which any check on lat will then flag).
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output logic [31:0] rdata,
                           output int lat);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    lat = 0;
    rdata = '0;
    while (lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
      if (mem_ready) begin
        rdata = mem_rdata;
        break;
      end
    end
    mem_valid = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset;
    i_reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_vec++;
    if ({wb.wb_cyc_o, wb.wb_stb_o, mem_ready, bus_err_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctl: cyc/stb/ready/err=%b required 0000",
               {wb.wb_cyc_o, wb.wb_stb_o, mem_ready, bus_err_o});
    end
    n_vec++;
    if ({mem_rdata, err_addr_o, wb.wb_adr_o, wb.wb_sel_o, wb.wb_cti_o, wb.wb_bte_o} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h err_addr=%h adr=%h sel=%h required all 0",
               mem_rdata, err_addr_o, wb.wb_adr_o, wb.wb_sel_o);
    end
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_read_comb_ack;
    logic [31:0] rd;
    int lat;
    setup_slave(0, 0, 1'b0, 1'b0, 32'h0000_00A5);
    do_access(32'h0200_0000, 32'h0, 4'b0000, rd, lat);
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL read_latency: got %0d required 2", lat); end
    n_vec++;
    if (rd !== 32'h0000_00A5) begin n_err++; $display("FAIL read_data: got %h required 000000a5", rd); end
    n_vec++;
    if (stb_total !== 1) begin n_err++; $display("FAIL read_stb_cycles: got %0d required 1", stb_total); end
    n_vec++;
    if ({sel_seen, we_seen} !== 5'b1111_0) begin
      n_err++; $display("FAIL read_sel_we: sel=%h we=%b required f/0", sel_seen, we_seen);
    end
    n_vec++;
    if (adr_seen !== 32'h0200_0000) begin
      n_err++; $display("FAIL read_adr: got %h required 02000000", adr_seen);
    end
  endtask

  task automatic test_write_wait;
    logic [31:0] rd;
    int lat;
    setup_slave(2, 0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    do_access(32'h0300_0010, 32'h1234_5678, 4'b0011, rd, lat);
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL write_latency: got %0d required 4", lat); end
    n_vec++;
    if (stb_total !== 3) begin n_err++; $display("FAIL write_stb_cycles: got %0d required 3", stb_total); end
    n_vec++;
    if ({sel_seen, we_seen} !== 5'b0011_1) begin
      n_err++; $display("FAIL write_sel_we: sel=%h we=%b required 3/1", sel_seen, we_seen);
    end
    n_vec++;
    if (dat_seen !== 32'h1234_5678) begin
      n_err++; $display("FAIL write_dat: got %h required 12345678", dat_seen);
    end
    n_vec++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL write_rdata: got %h required 0", rd); end
    n_vec++;
    if (bus_err_o !== 1'b0) begin n_err++; $display("FAIL write_no_err: got %b required 0", bus_err_o); end
  endtask

  task automatic test_retry_ok;
    logic [31:0] rd;
    int lat;
    setup_slave(0, 2, 1'b0, 1'b0, 32'h0BAD_F00D);
    do_access(32'h0400_0004, 32'h0, 4'b0000, rd, lat);
    n_vec++;
    if (lat !== 6) begin n_err++; $display("FAIL retry_latency: got %0d required 6", lat); end
    n_vec++;
    if (stb_rises !== 3 || stb_total !== 3) begin
      n_err++; $display("FAIL retry_attempts: rises=%0d stb=%0d required 3/3", stb_rises, stb_total);
    end
    n_vec++;
    if (rd !== 32'h0BAD_F00D || bus_err_o !== 1'b0) begin
      n_err++; $display("FAIL retry_result: rdata=%h err=%b required 0badf00d/0", rd, bus_err_o);
    end
  endtask

  task automatic test_retry_exhaust;
    logic [31:0] rd;
    int lat;
    setup_slave(0, 4, 1'b0, 1'b0, 32'h1111_1111);
    do_access(32'h0500_0008, 32'h0, 4'b0000, rd, lat);
    n_vec++;
    if (lat !== 8) begin n_err++; $display("FAIL rtyx_latency: got %0d required 8", lat); end
    n_vec++;
    if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rtyx_data: got %h required deadbeef", rd); end
    n_vec++;
    if (bus_err_o !== 1'b1 || err_addr_o !== 32'h0500_0008) begin
      n_err++; $display("FAIL rtyx_err: err=%b addr=%h required 1/05000008", bus_err_o, err_addr_o);
    end
    bus_err_clr_i = 1'b1;
    @(posedge i_clk); #1;
    bus_err_clr_i = 1'b0;
    n_vec++;
    if (bus_err_o !== 1'b0 || err_addr_o !== 32'h0500_0008 || mem_rdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL err_clear: err=%b addr=%h rdata=%h required 0/05000008/deadbeef",
                        bus_err_o, err_addr_o, mem_rdata);
    end
  endtask

  task automatic test_timeout_and_prio;
    logic [31:0] rd;
    int lat;
    setup_slave(0, 0, 1'b1, 1'b0, 32'h2222_2222);
    do_access(32'h0600_000C, 32'h0, 4'b0000, rd, lat);
    n_vec++;
    if (stb_total !== 8 || lat !== 9) begin
      n_err++; $display("FAIL timeout_timing: stb=%0d lat=%0d required 8/9", stb_total, lat);
    end
    n_vec++;
    if (rd !== 32'hDEAD_BEEF || bus_err_o !== 1'b1) begin
      n_err++; $display("FAIL timeout_result: rdata=%h err=%b required deadbeef/1", rd, bus_err_o);
    end
    bus_err_clr_i = 1'b1;
    @(posedge i_clk); #1;
    bus_err_clr_i = 1'b0;
    setup_slave(0, 0, 1'b0, 1'b1, 32'h3333_3333);
    do_access(32'h0700_0020, 32'h0, 4'b0000, rd, lat);
    n_vec++;
    if (rd !== 32'hDEAD_BEEF || bus_err_o !== 1'b1 || err_addr_o !== 32'h0700_0020 || lat !== 2) begin
      n_err++; $display("FAIL err_over_ack: rdata=%h err=%b addr=%h lat=%0d required deadbeef/1/07000020/2",
                        rd, bus_err_o, err_addr_o, lat);
    end
  endtask

  task automatic test_reset_in_bus;
    logic [31:0] rd;
    int lat;
    logic saw_ready;
    setup_slave(0, 0, 1'b1, 1'b0, 32'h4444_4444);
    mem_addr  = 32'h0800_0000;
    mem_wstrb = 4'b0000;
    mem_valid = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    n_vec++;
    if (wb.wb_stb_o !== 1'b1) begin n_err++; $display("FAIL rst_bus_entry: stb=%b required 1", wb.wb_stb_o); end
    i_reset_n = 1'b0;
    mem_valid = 1'b0;
    @(posedge i_clk); #1;
    n_vec++;
    if ({wb.wb_cyc_o, wb.wb_stb_o, mem_ready, bus_err_o} !== 4'b0000) begin
      n_err++; $display("FAIL rst_in_bus: cyc/stb/ready/err=%b required 0000",
                        {wb.wb_cyc_o, wb.wb_stb_o, mem_ready, bus_err_o});
    end
    i_reset_n = 1'b1;
    saw_ready = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
      saw_ready |= mem_ready | wb.wb_stb_o;
    end
    n_vec++;
    if (saw_ready !== 1'b0) begin n_err++; $display("FAIL rst_quiet: activity=%b required 0", saw_ready); end
    setup_slave(1, 0, 1'b0, 1'b0, 32'h5A5A_0001);
    do_access(32'h0800_0040, 32'h0, 4'b0000, rd, lat);
    n_vec++;
    if (rd !== 32'h5A5A_0001 || lat !== 3 || bus_err_o !== 1'b0) begin
      n_err++; $display("FAIL rst_after_access: rdata=%h lat=%0d err=%b required 5a5a0001/3/0",
                        rd, lat, bus_err_o);
    end
  endtask

  initial begin
    i_reset_n     = 1'b0;
    mem_valid     = 1'b0;
    mem_instr     = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    bus_err_clr_i = 1'b0;
    slv_wait      = 0;
    slv_rty_n     = 0;
    slv_silent    = 1'b1;
    slv_both      = 1'b0;
    slv_rdata     = '0;
    slv_clr       = 1'b1;
    test_reset();
    test_read_comb_ack();
    test_write_wait();
    test_retry_ok();
    test_retry_exhaust();
    test_timeout_and_prio();
    test_reset_in_bus();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
